// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the synchronous data memory.
// Optional build macro DMEM_PARITY_EN (see dmem_array) adds one even-parity bit per word.
package dmem_pkg;

   localparam int DMEM_DATA_W = 24;
   localparam int BYTES       = DMEM_DATA_W / 8;
   // Widest word the parity helper accepts; narrower words are zero-extended.
   localparam int PAR_MAX_W   = 1024;

   typedef enum logic {
      INIT,
      READY
   } dmem_state_t;

   // Even parity: XOR of all bits (zero-extension does not change it).
   function automatic logic parity(input logic [PAR_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-lane merge on write and a
// combinational read of the addressed word. The merge reuses that same read,
// so the array stays strictly single-port.
// With DMEM_PARITY_EN defined, a parity bit per word is stored alongside the
// data and compared on read; otherwise par_err is tied low.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 24,
   parameter int IDX_W  = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   output logic [DATA_W-1:0]     rdata,
   output logic                  par_err
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] merged;

   // Combinational read of the addressed word.
   always_comb begin
      rdata = mem[addr];
   end

   // Byte-lane merge: enabled lanes take new data, others keep the old word.
   for (genvar b = 0; b < NB; b++) begin : g_lane
      assign merged[8*b +: 8] = wbe[b] ? wdata[8*b +: 8] : rdata[8*b +: 8];
   end

   // Storage write; no reset, the clear sweep initialises contents.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= merged;
   end

`ifdef DMEM_PARITY_EN
   logic par_mem [DEPTH];

   // Parity is taken over the merged word, so partial writes stay consistent.
   always_ff @(posedge clk) begin
      if (we) par_mem[addr] <= parity(PAR_MAX_W'(merged));
   end

   // Mismatch between stored parity and parity of stored data.
   always_comb begin
      par_err = par_mem[addr] ^ parity(PAR_MAX_W'(rdata));
   end
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_sync.sv
// dmem_sync: single-port synchronous data memory with byte enables,
// registered reads, out-of-range flagging and a hardware clear sweep.
// Optional build macro DMEM_PARITY_EN enables per-word parity checking.
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 24,
   parameter int ADDR_W = 24
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Req,
   input  logic                  MemWrite,
   input  logic [ADDR_W-1:0]     Address,
   input  logic [DATA_W-1:0]     WriteData,
   input  logic [DATA_W/8-1:0]   ByteEn,
   input  logic                  Clr,
   output logic                  Ready,
   output logic                  RdValid,
   output logic [DATA_W-1:0]     MemData,
   output logic                  AddrErr,
   output logic                  ParErr
);

   localparam int                NB       = DATA_W / 8;
   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   dmem_state_t       state;
   logic [IDX_W-1:0]  clr_ptr;
   logic              in_range;
   logic              accept;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_addr;
   logic [DATA_W-1:0] arr_wdata;
   logic [NB-1:0]     arr_wbe;
   logic [DATA_W-1:0] arr_rdata;
   logic              arr_par_err;

   assign in_range = (Address < DEPTH_A);
   assign accept   = Req && (state == READY);

   // Array port mux: the sweep owns the port in INIT, the requester in READY.
   always_comb begin
      arr_we    = 1'b0;
      arr_addr  = '0;
      arr_wdata = '0;
      arr_wbe   = '0;
      if (state == INIT) begin
         arr_we    = 1'b1;
         arr_addr  = clr_ptr;
         arr_wdata = '0;
         arr_wbe   = '1;
      end else begin
         arr_we    = accept && MemWrite && in_range;
         arr_addr  = in_range ? Address[IDX_W-1:0] : '0;
         arr_wdata = WriteData;
         arr_wbe   = ByteEn;
      end
   end

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (Clk),
      .we      (arr_we),
      .addr    (arr_addr),
      .wdata   (arr_wdata),
      .wbe     (arr_wbe),
      .rdata   (arr_rdata),
      .par_err (arr_par_err)
   );

   // FSM, clear pointer and all registered outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= INIT;
         clr_ptr <= '0;
         Ready   <= 1'b0;
         RdValid <= 1'b0;
         MemData <= '0;
         AddrErr <= 1'b0;
         ParErr  <= 1'b0;
      end else begin
         RdValid <= 1'b0;
         AddrErr <= 1'b0;
         ParErr  <= 1'b0;
         case (state)
            INIT: begin
               Ready <= 1'b0;
               if (clr_ptr == LAST_IDX) begin
                  state   <= READY;
                  Ready   <= 1'b1;
                  clr_ptr <= '0;
               end else begin
                  clr_ptr <= clr_ptr + IDX_W'(1);
               end
            end
            READY: begin
               if (accept) begin
                  AddrErr <= !in_range;
                  if (!MemWrite) begin
                     RdValid <= 1'b1;
                     MemData <= in_range ? arr_rdata : '0;
                     ParErr  <= in_range && arr_par_err;
                  end
               end
               // A request in the same cycle as Clr still completes above.
               if (Clr) begin
                  state   <= INIT;
                  Ready   <= 1'b0;
                  clr_ptr <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_sync.sv
// tb_dmem_sync: table-driven and directed checks for dmem_sync with a
// scoreboard queue of expected outputs per accepted cycle.
module tb_dmem_sync;

   localparam int DW  = 24;
   localparam int DEP = 24;
   localparam int AW  = 24;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          Req;
   logic          MemWrite;
   logic [AW-1:0] Address;
   logic [DW-1:0] WriteData;
   logic [2:0]    ByteEn;
   logic          Clr;
   logic          Ready;
   logic          RdValid;
   logic [DW-1:0] MemData;
   logic          AddrErr;
   logic          ParErr;

   always #5 Clk = ~Clk;

   dmem_sync #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Req       (Req),
      .MemWrite  (MemWrite),
      .Address   (Address),
      .WriteData (WriteData),
      .ByteEn    (ByteEn),
      .Clr       (Clr),
      .Ready     (Ready),
      .RdValid   (RdValid),
      .MemData   (MemData),
      .AddrErr   (AddrErr),
      .ParErr    (ParErr)
   );

   typedef struct {
      logic          rdy;
      logic          rv;
      logic [DW-1:0] data;
      logic          ae;
      logic          pe;
   } exp_t;

   typedef struct {
      logic          req;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [2:0]    be;
      logic          rv;
      logic [DW-1:0] data;
      logic          ae;
   } vec_t;

   int            checks   = 0;
   int            failures = 0;
   exp_t          sbq[$];
   logic [DW-1:0] model [DEP];
   logic [DW-1:0] last_rd;
   vec_t          vt [15];

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk24(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEP; i++) model[i] = '0;
   endfunction

   // Reference behaviour of one READY-state cycle.
   function automatic exp_t model_access(input logic rq, input logic we, input logic [AW-1:0] a,
                                         input logic [DW-1:0] wd, input logic [2:0] be);
      exp_t e;
      e.rdy = 1'b1; e.rv = 1'b0; e.ae = 1'b0; e.pe = 1'b0;
      if (rq) begin
         if (a < DEP) begin
            if (we) begin
               for (int b = 0; b < 3; b++)
                  if (be[b]) model[a[4:0]][8*b +: 8] = wd[8*b +: 8];
            end else begin
               e.rv    = 1'b1;
               last_rd = model[a[4:0]];
            end
         end else begin
            e.ae = 1'b1;
            if (!we) begin
               e.rv    = 1'b1;
               last_rd = '0;
            end
         end
      end
      e.data = last_rd;
      return e;
   endfunction

   // Drive one cycle at a falling edge, queue the expectation, compare after the edge.
   task automatic op(input logic rq, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [2:0] be, input exp_t e, input string nm);
      exp_t x;
      Req = rq; MemWrite = we; Address = a; WriteData = wd; ByteEn = be;
      sbq.push_back(e);
      @(posedge Clk);
      @(negedge Clk);
      Req = 1'b0;
      x = sbq.pop_front();
      chk1 ({nm, ".ready"},   Ready,   x.rdy);
      chk1 ({nm, ".rdvalid"}, RdValid, x.rv);
      chk24({nm, ".memdata"}, MemData, x.data);
      chk1 ({nm, ".addrerr"}, AddrErr, x.ae);
      chk1 ({nm, ".parerr"},  ParErr,  x.pe);
   endtask

   task automatic mop(input logic rq, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [2:0] be, input string nm);
      exp_t e;
      e = model_access(rq, we, a, wd, be);
      op(rq, we, a, wd, be, e, nm);
   endtask

   // Count sweep edges; Ready must rise exactly on the DEP-th one.
   task automatic sweep(input string nm);
      for (int i = 1; i <= DEP; i++) begin
         @(posedge Clk);
         @(negedge Clk);
         chk1({nm, ".ready"}, Ready, logic'(i == DEP));
         chk1({nm, ".rdvalid"}, RdValid, 1'b0);
         chk1({nm, ".addrerr"}, AddrErr, 1'b0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: run did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      //                  req  we    addr    wdata      be      rv    data       ae
      vt[0]  = '{1'b1, 1'b1, 24'd5,  24'hABCDEF, 3'b111, 1'b0, 24'h000000, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 24'd5,  24'h000000, 3'b000, 1'b1, 24'hABCDEF, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 24'd5,  24'h112233, 3'b010, 1'b0, 24'hABCDEF, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 24'd5,  24'h000000, 3'b000, 1'b1, 24'hAB22EF, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 24'd30, 24'h123456, 3'b111, 1'b0, 24'hAB22EF, 1'b1};
      vt[5]  = '{1'b1, 1'b0, 24'd30, 24'h000000, 3'b000, 1'b1, 24'h000000, 1'b1};
      vt[6]  = '{1'b1, 1'b1, 24'd7,  24'hFFFFFF, 3'b000, 1'b0, 24'h000000, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 24'd7,  24'h000000, 3'b000, 1'b1, 24'h000000, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 24'd23, 24'hC0FFEE, 3'b101, 1'b0, 24'h000000, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 24'd23, 24'h000000, 3'b000, 1'b1, 24'hC000EE, 1'b0};
      vt[10] = '{1'b1, 1'b1, 24'd0,  24'h5A5A5A, 3'b100, 1'b0, 24'hC000EE, 1'b0};
      vt[11] = '{1'b1, 1'b0, 24'd0,  24'h000000, 3'b000, 1'b1, 24'h5A0000, 1'b0};
      vt[12] = '{1'b1, 1'b0, 24'd24, 24'h000000, 3'b000, 1'b1, 24'h000000, 1'b1};
      vt[13] = '{1'b1, 1'b0, 24'd23, 24'h000000, 3'b000, 1'b1, 24'hC000EE, 1'b0};
      vt[14] = '{1'b0, 1'b0, 24'd23, 24'h000000, 3'b000, 1'b0, 24'hC000EE, 1'b0};

      model_clear();
      last_rd = '0;
      Rst_n = 1'b0; Req = 1'b0; MemWrite = 1'b0; Address = '0;
      WriteData = '0; ByteEn = '0; Clr = 1'b0;

      // Reset values
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk1 ("reset.ready",   Ready,   1'b0);
      chk1 ("reset.rdvalid", RdValid, 1'b0);
      chk24("reset.memdata", MemData, '0);
      chk1 ("reset.addrerr", AddrErr, 1'b0);
      chk1 ("reset.parerr",  ParErr,  1'b0);

      // Initial sweep with an out-of-range read held and Clr pulsed; both ignored.
      Req = 1'b1; MemWrite = 1'b0; Address = 24'd30;
      Rst_n = 1'b1;
      for (int i = 1; i <= DEP; i++) begin
         Clr = (i >= 5 && i <= 10);
         @(posedge Clk);
         @(negedge Clk);
         chk1("init.ready",   Ready,   logic'(i == DEP));
         chk1("init.rdvalid", RdValid, 1'b0);
         chk1("init.addrerr", AddrErr, 1'b0);
      end
      Clr = 1'b0; Req = 1'b0;

      // Every word reads back zero after the sweep.
      for (int i = 0; i < DEP; i++) mop(1'b1, 1'b0, AW'(i), '0, 3'b000, "zero_rd");

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         exp_t e;
         void'(model_access(vt[i].req, vt[i].we, vt[i].a, vt[i].wd, vt[i].be));
         e.rdy = 1'b1; e.rv = vt[i].rv; e.data = vt[i].data; e.ae = vt[i].ae; e.pe = 1'b0;
         op(vt[i].req, vt[i].we, vt[i].a, vt[i].wd, vt[i].be, e, $sformatf("vec%0d", i));
      end

      // Whole array against the model (out-of-range write must not have landed).
      for (int i = 0; i < DEP; i++) mop(1'b1, 1'b0, AW'(i), '0, 3'b000, "full_rd");

      // Clr together with a write: write is accepted, then the sweep runs.
      begin
         exp_t e;
         Clr = 1'b1;
         e = model_access(1'b1, 1'b1, 24'd2, 24'h000001, 3'b111);
         e.rdy = 1'b0;
         op(1'b1, 1'b1, 24'd2, 24'h000001, 3'b111, e, "clr_wr");
         Clr = 1'b0;
         model_clear();
      end
      sweep("clr_sweep");
      mop(1'b1, 1'b0, 24'd2, '0, 3'b000, "clr_rd2");

      // Reset in the middle of a sweep restarts it from word 0.
      mop(1'b1, 1'b1, 24'd4, 24'h123456, 3'b111, "pre_rst_wr");
      mop(1'b1, 1'b0, 24'd4, '0, 3'b000, "pre_rst_rd");
      Clr = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Clr = 1'b0;
      repeat (9) @(posedge Clk);
      @(negedge Clk);
      Rst_n = 1'b0;
      #1;
      chk1 ("midrst.ready",   Ready,   1'b0);
      chk24("midrst.memdata", MemData, '0);
      chk1 ("midrst.rdvalid", RdValid, 1'b0);
      @(negedge Clk);
      Rst_n = 1'b1;
      model_clear();
      last_rd = '0;
      sweep("rst_sweep");
      mop(1'b1, 1'b0, 24'd4, '0, 3'b000, "post_rst_rd4");

      // Parity
      mop(1'b1, 1'b1, 24'd3, 24'h000007, 3'b111, "par_wr");
      mop(1'b1, 1'b0, 24'd3, '0, 3'b000, "par_rd_clean");
`ifdef DMEM_PARITY_EN
      begin
         exp_t e;
         dut.u_array.par_mem[3] = ~dut.u_array.par_mem[3];
         e = model_access(1'b1, 1'b0, 24'd3, '0, 3'b000);
         e.pe = 1'b1;
         op(1'b1, 1'b0, 24'd3, '0, 3'b000, e, "par_rd_flip");
      end
`else
      mop(1'b1, 1'b0, 24'd3, '0, 3'b000, "par_rd_off");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
